hub75_capture: RTL and testbench

HUB75_CAPTURE -- requirements
Module: hub75_capture

---
 rtl/hub75_pkg.sv | 23 ++
 rtl/hub75_sync_edge.sv | 40 ++++
 rtl/hub75_capture.sv | 272 +++++++++++++++++++++++++++
 tb/tb_hub75_capture.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// hub75_pkg: shared types for the HUB75 column capture block.
// Beat fields are sized for the default geometry; modules slice to their own widths.
package hub75_pkg;

  localparam int NUM_PLANES_DEF = 3;
  localparam int ROWS_MAX       = 64;
  localparam int CNT_W_MAX      = 11;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WAIT_OE,
    MEASURE
  } state_e;

  typedef struct packed {
    logic [2:0][ROWS_MAX-1:0] data0;
    logic [2:0][ROWS_MAX-1:0] data1;
    logic [1:0]               plane;
    logic [CNT_W_MAX-1:0]     ontime;
  } beat_t;

endpackage

// File: rtl/hub75_sync_edge.sv
// hub75_sync_edge: 2-flop synchroniser plus edge detector for one panel line.
// RST_VAL lets active-low lines reset to their idle level.
module hub75_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
      s3_q <= RST_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign q    = s2_q;
  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/hub75_capture.sv
// hub75_capture: turns a sniffed HUB75 panel stream into one AXI-Stream beat per column.
// Define HUB75_CAPTURE_ONTIME_EN to measure the OE on-time of each plane.
module hub75_capture
  import hub75_pkg::*;
#(
  parameter int NUM_ROWS   = 64,
  parameter int NUM_PLANES = NUM_PLANES_DEF,
  parameter int PERIOD     = 10,
  parameter int CNT_W      = 11
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [2:0]                hub_rgb0,
  input  logic [2:0]                hub_rgb1,
  input  logic                      hub_clk,
  input  logic                      hub_latch,
  input  logic                      hub_oe,
  output logic [2:0][NUM_ROWS-1:0] m_data0,
  output logic [2:0][NUM_ROWS-1:0] m_data1,
  output logic [1:0]                m_plane,
  output logic [CNT_W-1:0]          m_ontime,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic                      m_tlast,
  output logic                      err_len,
  output logic                      err_overflow,
  output logic                      err_ontime
);

  localparam int IX_W = $clog2(NUM_ROWS);
  localparam int EC_W = $clog2(NUM_ROWS + 2);
  localparam logic [EC_W-1:0] ROWS_C = EC_W'(NUM_ROWS);
  localparam logic [EC_W-1:0] SAT_C  = EC_W'(NUM_ROWS + 1);
  localparam logic [1:0] PL_LAST = 2'(NUM_PLANES - 1);

  logic clk_rise, latch_rise;
  logic [1:0] clk_unused, latch_unused;
  logic [5:0] rgb_s1_q, rgb_s1_d, rgb_s2_q, rgb_s2_d;

  state_e state_q, state_d;
  logic [EC_W-1:0] ec_q, ec_d;
  logic [2:0][NUM_ROWS-1:0] sh0_q, sh0_d, sh1_q, sh1_d;
  logic [1:0] plane_q, plane_d;
  logic err_len_q, err_len_d;
  logic err_ovf_q, err_ovf_d;
  beat_t beat_q, beat_d;
  logic valid_q, valid_d;
  logic last_q, last_d;

  logic shift_en;
  logic [IX_W-1:0] shift_ix;
  logic emit;
  beat_t col_now, ebeat;

  hub75_sync_edge #(.RST_VAL(1'b0)) u_clk (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .d      (hub_clk),
    .q      (clk_unused[0]),
    .rise   (clk_rise),
    .fall   (clk_unused[1])
  );

  hub75_sync_edge #(.RST_VAL(1'b0)) u_latch (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .d      (hub_latch),
    .q      (latch_unused[0]),
    .rise   (latch_rise),
    .fall   (latch_unused[1])
  );

`ifdef HUB75_CAPTURE_ONTIME_EN
  logic oe_lvl, oe_rise, oe_fall;
  beat_t col_q, col_d;
  logic [CNT_W-1:0] ontime_q, ontime_d;
  logic err_ont_q, err_ont_d;

  hub75_sync_edge #(.RST_VAL(1'b1)) u_oe (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .d      (hub_oe),
    .q      (oe_lvl),
    .rise   (oe_rise),
    .fall   (oe_fall)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^{hub_oe, PERIOD[0]};
`endif

  always_comb begin
    rgb_s1_d = {hub_rgb1, hub_rgb0};
    rgb_s2_d = rgb_s1_q;
  end

  always_comb begin
    col_now = '0;
    for (int c = 0; c < 3; c++) begin
      col_now.data0[c][NUM_ROWS-1:0] = sh0_q[c];
      col_now.data1[c][NUM_ROWS-1:0] = sh1_q[c];
    end
    col_now.plane = plane_q;
`ifdef HUB75_CAPTURE_ONTIME_EN
    ebeat = col_q;
    ebeat.ontime = '0;
    ebeat.ontime[CNT_W-1:0] = ontime_q;
`else
    ebeat = col_now;
`endif
  end

  always_comb begin
    state_d   = state_q;
    ec_d      = ec_q;
    sh0_d     = sh0_q;
    sh1_d     = sh1_q;
    plane_d   = plane_q;
    err_len_d = err_len_q;
    shift_en  = 1'b0;
    shift_ix  = ec_q[IX_W-1:0];
    emit      = 1'b0;
`ifdef HUB75_CAPTURE_ONTIME_EN
    col_d     = col_q;
    ontime_d  = ontime_q;
    err_ont_d = err_ont_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (clk_rise) begin
          shift_en = 1'b1;
          shift_ix = '0;
          ec_d     = EC_W'(1);
          state_d  = SHIFT;
        end else if (latch_rise) begin
          err_len_d = 1'b1;
        end
      end
      SHIFT: begin
        if (latch_rise) begin
          ec_d    = '0;
          state_d = IDLE;
          if (ec_q != ROWS_C) begin
            err_len_d = 1'b1;
          end else begin
            plane_d = (plane_q == PL_LAST) ? 2'd0 : plane_q + 2'd1;
`ifdef HUB75_CAPTURE_ONTIME_EN
            col_d   = col_now;
            state_d = WAIT_OE;
`else
            emit    = 1'b1;
`endif
          end
        end else if (clk_rise) begin
          shift_en = (ec_q < ROWS_C);
          if (ec_q != SAT_C) ec_d = ec_q + 1'b1;
        end
      end
`ifdef HUB75_CAPTURE_ONTIME_EN
      WAIT_OE, MEASURE: begin
        // A new column starting early truncates the plane's on-time.
        if (clk_rise) begin
          emit      = 1'b1;
          ontime_d  = '0;
          err_ont_d = 1'b1;
          shift_en  = 1'b1;
          shift_ix  = '0;
          ec_d      = EC_W'(1);
          state_d   = SHIFT;
        end else if (state_q == WAIT_OE) begin
          if (oe_fall) begin
            state_d  = MEASURE;
            ontime_d = CNT_W'(1);
          end
        end else if (oe_rise) begin
          emit     = 1'b1;
          ontime_d = '0;
          state_d  = IDLE;
        end else if (!oe_lvl && ontime_q != '1) begin
          ontime_d = ontime_q + 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
`ifdef HUB75_CAPTURE_ONTIME_EN
    if (emit && 32'(ontime_q) != PERIOD * (32'(col_q.plane) + 1))
      err_ont_d = 1'b1;
`endif
    if (shift_en) begin
      for (int c = 0; c < 3; c++) begin
        sh0_d[c][shift_ix] = rgb_s2_q[c];
        sh1_d[c][shift_ix] = rgb_s2_q[3+c];
      end
    end
  end

  always_comb begin
    beat_d    = beat_q;
    valid_d   = valid_q;
    last_d    = last_q;
    err_ovf_d = err_ovf_q;
    if (valid_q && m_tready) valid_d = 1'b0;
    if (emit) begin
      if (valid_q && !m_tready) begin
        err_ovf_d = 1'b1;
      end else begin
        beat_d  = ebeat;
        valid_d = 1'b1;
        last_d  = (ebeat.plane == PL_LAST);
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rgb_s1_q  <= '0;
      rgb_s2_q  <= '0;
      state_q   <= IDLE;
      ec_q      <= '0;
      sh0_q     <= '0;
      sh1_q     <= '0;
      plane_q   <= '0;
      err_len_q <= 1'b0;
      err_ovf_q <= 1'b0;
      beat_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
`ifdef HUB75_CAPTURE_ONTIME_EN
      col_q     <= '0;
      ontime_q  <= '0;
      err_ont_q <= 1'b0;
`endif
    end else begin
      rgb_s1_q  <= rgb_s1_d;
      rgb_s2_q  <= rgb_s2_d;
      state_q   <= state_d;
      ec_q      <= ec_d;
      sh0_q     <= sh0_d;
      sh1_q     <= sh1_d;
      plane_q   <= plane_d;
      err_len_q <= err_len_d;
      err_ovf_q <= err_ovf_d;
      beat_q    <= beat_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
`ifdef HUB75_CAPTURE_ONTIME_EN
      col_q     <= col_d;
      ontime_q  <= ontime_d;
      err_ont_q <= err_ont_d;
`endif
    end
  end

  for (genvar c = 0; c < 3; c++) begin : g_out
    assign m_data0[c] = beat_q.data0[c][NUM_ROWS-1:0];
    assign m_data1[c] = beat_q.data1[c][NUM_ROWS-1:0];
  end

  assign m_plane      = beat_q.plane;
  assign m_ontime     = beat_q.ontime[CNT_W-1:0];
  assign m_tvalid     = valid_q;
  assign m_tlast      = last_q;
  assign err_len      = err_len_q;
  assign err_overflow = err_ovf_q;
`ifdef HUB75_CAPTURE_ONTIME_EN
  assign err_ontime   = err_ont_q;
`else
  assign err_ontime   = 1'b0;
`endif

endmodule

// File: tb/tb_hub75_capture.sv
// tb_hub75_capture: randomized panel stream against a column-level model.
// Expected beats are queued at latch time and popped by a handshake monitor.
`timescale 1ns/1ps
module tb_hub75_capture;

  localparam int ROWS = 64;
  localparam int PL   = 3;
  localparam int PER  = 10;
  localparam int CW   = 11;
`ifdef HUB75_CAPTURE_ONTIME_EN
  localparam bit ONT = 1'b1;
`else
  localparam bit ONT = 1'b0;
`endif

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic [2:0] hub_rgb0 = '0;
  logic [2:0] hub_rgb1 = '0;
  logic hub_clk = 1'b0;
  logic hub_latch = 1'b0;
  logic hub_oe = 1'b1;
  logic m_tready = 1'b1;
  logic [2:0][ROWS-1:0] m_data0, m_data1;
  logic [1:0] m_plane;
  logic [CW-1:0] m_ontime;
  logic m_tvalid, m_tlast;
  logic err_len, err_overflow, err_ontime;

  typedef struct {
    logic [2:0][ROWS-1:0] d0;
    logic [2:0][ROWS-1:0] d1;
    int plane;
    int ontime;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int plane_m = 0;
  bit e_len = 0, e_ovf = 0, e_ont = 0, held_m = 0;
  logic [2:0][ROWS-1:0] col0, col1;

  hub75_capture dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .hub_rgb0     (hub_rgb0),
    .hub_rgb1     (hub_rgb1),
    .hub_clk      (hub_clk),
    .hub_latch    (hub_latch),
    .hub_oe       (hub_oe),
    .m_data0      (m_data0),
    .m_data1      (m_data1),
    .m_plane      (m_plane),
    .m_ontime     (m_ontime),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tlast      (m_tlast),
    .err_len      (err_len),
    .err_overflow (err_overflow),
    .err_ontime   (err_ontime)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input logic [191:0] act,
                     input logic [191:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp_v);
    end
  endtask

  always @(negedge clk_in) begin
    if (!rst_in && m_tvalid && m_tready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got plane %0d, no beat required", m_plane);
      end else begin
        mon_e = q.pop_front();
        chk("beat_data0", m_data0, mon_e.d0);
        chk("beat_data1", m_data1, mon_e.d1);
        chk("beat_plane", m_plane, mon_e.plane);
        chk("beat_ontime", m_ontime, mon_e.ontime);
        chk("beat_last", m_tlast, mon_e.plane == PL - 1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic new_col();
    for (int c = 0; c < 3; c++) begin
      col0[c] = {$urandom, $urandom};
      col1[c] = {$urandom, $urandom};
    end
  endtask

  task automatic set_rgb(input int k);
    for (int c = 0; c < 3; c++) begin
      hub_rgb0[c] = col0[c][k];
      hub_rgb1[c] = col1[c][k];
    end
  endtask

  task automatic shift_bits(input int lo, input int hi);
    for (int k = lo; k < hi; k++) begin
      set_rgb(k % ROWS);
      tick(2);
      hub_clk = 1'b1;
      tick(2);
      hub_clk = 1'b0;
    end
    tick(2);
  endtask

  task automatic model_latch(input int n, input int on_len);
    exp_t e;
    if (n != ROWS) begin
      e_len = 1'b1;
    end else begin
      e.d0 = col0;
      e.d1 = col1;
      e.plane = plane_m;
      e.ontime = ONT ? on_len : 0;
      if (ONT && on_len != PER * (plane_m + 1)) e_ont = 1'b1;
      plane_m = (plane_m + 1) % PL;
      if (held_m) begin
        e_ovf = 1'b1;
      end else begin
        q.push_back(e);
        if (!m_tready) held_m = 1'b1;
      end
    end
  endtask

  task automatic do_latch();
    hub_latch = 1'b1;
    tick(2);
    hub_latch = 1'b0;
    tick(2);
  endtask

  task automatic oe_pulse(input int len);
    hub_oe = 1'b0;
    tick(len);
    hub_oe = 1'b1;
    tick(6);
  endtask

  task automatic column(input int n, input int on_len);
    new_col();
    shift_bits(0, n);
    model_latch(n, on_len);
    do_latch();
    if (on_len > 0) oe_pulse(on_len);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      tick(1);
      n++;
    end
    chk("drain_queue_empty", q.size(), 0);
  endtask

  task automatic chk_flags();
    chk("err_len", err_len, e_len);
    chk("err_overflow", err_overflow, e_ovf);
    chk("err_ontime", err_ontime, e_ont);
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick(2);
    rst_in = 1'b0;
    tick(2);
    plane_m = 0;
    e_len = 0;
    e_ovf = 0;
    e_ont = 0;
    held_m = 0;
    q.delete();
  endtask

  initial begin
    tick(3);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_data0", m_data0, 0);
    chk("rst_plane", m_plane, 0);
    chk("rst_ontime", m_ontime, 0);
    chk("rst_tlast", m_tlast, 0);
    chk_flags();
    rst_in = 1'b0;
    tick(2);

    // single column: red on top half, blue on bottom half
    col0 = '0;
    col0[0] = '1;
    col1 = '0;
    col1[2] = '1;
    shift_bits(0, ROWS);
    model_latch(ROWS, 10);
    do_latch();
    oe_pulse(10);
    drain();
    chk_flags();

    // three planes with nominal on-times
    do_reset();
    column(ROWS, 10);
    column(ROWS, 20);
    column(ROWS, 30);
    drain();
    chk_flags();

    // short column then a good one that must still be plane 0
    do_reset();
    column(ROWS - 1, 0);
    tick(20);
    chk_flags();
    column(ROWS, 10);
    drain();
    chk_flags();

    // back-pressure across two columns
    do_reset();
    m_tready = 1'b0;
    column(ROWS, 10);
    column(ROWS, 20);
    tick(4);
    chk("held_tvalid", m_tvalid, 1);
    chk("held_plane", m_plane, 0);
    chk("held_data0", m_data0, q[0].d0);
    chk_flags();
    m_tready = 1'b1;
    held_m = 1'b0;
    tick(4);
    column(ROWS, 30);
    drain();
    chk_flags();

    // next column starts while OE is still low
    do_reset();
    new_col();
    shift_bits(0, ROWS);
    model_latch(ROWS, 5);
    do_latch();
    new_col();
    set_rgb(0);
    hub_oe = 1'b0;
    tick(5);
    hub_clk = 1'b1;
    tick(2);
    hub_clk = 1'b0;
    tick(2);
    hub_oe = 1'b1;
    tick(4);
    shift_bits(1, ROWS);
    model_latch(ROWS, 20);
    do_latch();
    oe_pulse(20);
    drain();
    chk_flags();

    // asynchronous reset in the middle of a shift
    do_reset();
    m_tready = 1'b0;
    column(ROWS, 10);
    column(ROWS - 3, 0);
    new_col();
    shift_bits(0, 20);
    rst_in = 1'b1;
    #2;
    chk("arst_tvalid", m_tvalid, 0);
    chk("arst_data0", m_data0, 0);
    chk("arst_data1", m_data1, 0);
    chk("arst_err_len", err_len, 0);
    tick(1);
    rst_in = 1'b0;
    m_tready = 1'b1;
    tick(2);
    plane_m = 0;
    e_len = 0;
    e_ovf = 0;
    e_ont = 0;
    held_m = 0;
    q.delete();
    column(ROWS, 10);
    drain();
    chk_flags();

    // randomized column lengths and on-times
    do_reset();
    for (int i = 0; i < 10; i++) begin
      int n;
      int on;
      n = ($urandom_range(0, 3) == 0) ? 60 + $urandom_range(0, 6) : ROWS;
      on = ($urandom_range(0, 1) == 0) ? PER * (plane_m + 1)
                                        : $urandom_range(3, 40);
      column(n, on);
    end
    drain();
    chk_flags();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
